// File: rtl/eb1_ifu_compress_enc_if.sv
// Stream bundle for the RV32 -> RVC compressor: 32-bit instruction input
// and 16-bit parcel output, both valid/ready.
interface eb1_ifu_compress_enc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_parcel;
    logic        out_last;
    logic        out_compressed;

    // Producer of instructions / consumer of parcels.
    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_parcel,
        input  out_last,
        input  out_compressed
    );

    // The compressor itself.
    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_parcel,
        output out_last,
        output out_compressed
    );
endinterface

// File: rtl/eb1_ifu_compress_enc.sv
// Streaming RV32 instruction compressor. Re-encodes a fixed RVC subset into
// one 16-bit parcel; anything else leaves as two parcels, low half first.
// Saturating counters track accepted and compressed instructions.
module eb1_ifu_compress_enc #(
    parameter bit          ENABLE = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_l,
    eb1_ifu_compress_enc_if.slave     bus,
    input  logic                      stat_clr,
    output logic [CNT_W-1:0]          cnt_total,
    output logic [CNT_W-1:0]          cnt_cmp
);

    typedef enum logic [0:0] {StEmpty, StHighPend} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic [15:0]       hi_half_q, hi_half_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_parcel_q, out_parcel_d;
    logic              out_last_q, out_last_d;
    logic              out_cmp_q, out_cmp_d;
    logic [CNT_W-1:0]  cnt_total_q, cnt_total_d;
    logic [CNT_W-1:0]  cnt_cmp_q, cnt_cmp_d;

    logic        adv;
    logic        accept;
    logic        cmp_hit;
    logic [15:0] cmp_code;

    // Instruction fields
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic        imm_small;
    logic        is_addi;
    logic        is_add;
    logic        is_op;
    logic        is_jalr0;
    logic        rd_is_rs1;
    logic        alu_regs_c;

    assign ins       = bus.in_instr;
    assign opc       = ins[6:0];
    assign rd        = ins[11:7];
    assign f3        = ins[14:12];
    assign rs1       = ins[19:15];
    assign rs2       = ins[24:20];
    assign f7        = ins[31:25];
    // imm[11:5] all equal to imm[5] means it fits in a 6-bit signed field
    assign imm_small = (&f7) | ~(|f7);
    assign is_addi   = (opc == 7'b0010011) && (f3 == 3'b000);
    assign is_op     = (opc == 7'b0110011);
    assign is_add    = is_op && (f3 == 3'b000) && (f7 == 7'b0000000);
    assign is_jalr0  = (opc == 7'b1100111) && (f3 == 3'b000) && (ins[31:20] == 12'h000);
    assign rd_is_rs1 = (rd == rs1);
    assign alu_regs_c = is_op && rd_is_rs1 && (rd[4:3] == 2'b01) && (rs2[4:3] == 2'b01);

    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = (state_q == StEmpty) & adv;
    assign accept       = bus.in_valid & bus.in_ready;

    // Match the RVC subset, first match wins
    always_comb begin
        cmp_hit  = 1'b0;
        cmp_code = 16'h0000;
        if (ENABLE) begin
            if (ins == 32'h0000_0013) begin
                cmp_hit  = 1'b1;
                cmp_code = 16'h0001;
            end else if (ins == 32'h0010_0073) begin
                cmp_hit  = 1'b1;
                cmp_code = 16'h9002;
            end else if (is_addi && rd_is_rs1 && (rd != 5'd0) && (ins[31:20] != 12'h000)
                         && imm_small) begin
                cmp_hit  = 1'b1;
                cmp_code = {3'b000, ins[25], rd, ins[24:20], 2'b01};
            end else if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm_small) begin
                cmp_hit  = 1'b1;
                cmp_code = {3'b010, ins[25], rd, ins[24:20], 2'b01};
            end else if (is_add && (rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
                cmp_hit  = 1'b1;
                cmp_code = {4'b1000, rd, rs2, 2'b10};
            end else if (is_add && rd_is_rs1 && (rd != 5'd0) && (rs2 != 5'd0)) begin
                cmp_hit  = 1'b1;
                cmp_code = {4'b1001, rd, rs2, 2'b10};
            end else if (is_jalr0 && (rd == 5'd0) && (rs1 != 5'd0)) begin
                cmp_hit  = 1'b1;
                cmp_code = {4'b1000, rs1, 5'b00000, 2'b10};
            end else if (is_jalr0 && (rd == 5'd1) && (rs1 != 5'd0)) begin
                cmp_hit  = 1'b1;
                cmp_code = {4'b1001, rs1, 5'b00000, 2'b10};
            end else if (alu_regs_c && (f7 == 7'b0100000) && (f3 == 3'b000)) begin
                cmp_hit  = 1'b1;
                cmp_code = {6'b100011, rd[2:0], 2'b00, rs2[2:0], 2'b01};
            end else if (alu_regs_c && (f7 == 7'b0000000) && (f3 == 3'b100)) begin
                cmp_hit  = 1'b1;
                cmp_code = {6'b100011, rd[2:0], 2'b01, rs2[2:0], 2'b01};
            end else if (alu_regs_c && (f7 == 7'b0000000) && (f3 == 3'b110)) begin
                cmp_hit  = 1'b1;
                cmp_code = {6'b100011, rd[2:0], 2'b10, rs2[2:0], 2'b01};
            end else if (alu_regs_c && (f7 == 7'b0000000) && (f3 == 3'b111)) begin
                cmp_hit  = 1'b1;
                cmp_code = {6'b100011, rd[2:0], 2'b11, rs2[2:0], 2'b01};
            end
        end
    end

    // Output register and high-half buffer; fields hold while stalled
    always_comb begin
        state_d      = state_q;
        hi_half_d    = hi_half_q;
        out_valid_d  = out_valid_q;
        out_parcel_d = out_parcel_q;
        out_last_d   = out_last_q;
        out_cmp_d    = out_cmp_q;
        if (adv) begin
            if (state_q == StHighPend) begin
                out_valid_d  = 1'b1;
                out_parcel_d = hi_half_q;
                out_last_d   = 1'b1;
                out_cmp_d    = 1'b0;
                state_d      = StEmpty;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_parcel_d = ins[15:0];
                out_cmp_d    = 1'b0;
                if (cmp_hit) begin
                    out_parcel_d = cmp_code;
                    out_last_d   = 1'b1;
                    out_cmp_d    = 1'b1;
                end else if (ins[1:0] != 2'b11) begin
                    out_last_d   = 1'b1;
                end else begin
                    out_last_d   = 1'b0;
                    hi_half_d    = ins[31:16];
                    state_d      = StHighPend;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Saturating statistics; clear beats a same-cycle increment
    always_comb begin
        cnt_total_d = cnt_total_q;
        cnt_cmp_d   = cnt_cmp_q;
        if (stat_clr) begin
            cnt_total_d = '0;
            cnt_cmp_d   = '0;
        end else if (accept) begin
            if (!(&cnt_total_q)) begin
                cnt_total_d = cnt_total_q + CntOne;
            end
            if (cmp_hit && !(&cnt_cmp_q)) begin
                cnt_cmp_d = cnt_cmp_q + CntOne;
            end
        end
    end

    // All state registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= StEmpty;
            hi_half_q    <= 16'h0000;
            out_valid_q  <= 1'b0;
            out_parcel_q <= 16'h0000;
            out_last_q   <= 1'b0;
            out_cmp_q    <= 1'b0;
            cnt_total_q  <= '0;
            cnt_cmp_q    <= '0;
        end else begin
            state_q      <= state_d;
            hi_half_q    <= hi_half_d;
            out_valid_q  <= out_valid_d;
            out_parcel_q <= out_parcel_d;
            out_last_q   <= out_last_d;
            out_cmp_q    <= out_cmp_d;
            cnt_total_q  <= cnt_total_d;
            cnt_cmp_q    <= cnt_cmp_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_parcel     = out_parcel_q;
    assign bus.out_last       = out_last_q;
    assign bus.out_compressed = out_cmp_q;
    assign cnt_total          = cnt_total_q;
    assign cnt_cmp            = cnt_cmp_q;

endmodule

// File: tb/tb_eb1_ifu_compress_enc.sv
// Bench for eb1_ifu_compress_enc: dut A (ENABLE=1, CNT_W=16) and
// dut B (ENABLE=0, CNT_W=2), directed vector table plus corner sequences.
module tb_eb1_ifu_compress_enc;

    typedef struct {
        logic [15:0] parcel;
        logic        last;
        logic        cmp;
        int          cyc;
    } rec_t;

    typedef struct {
        int          which;
        logic [31:0] instr;
        bit          two;
        logic [15:0] p0;
        bit          c0;
        logic [15:0] p1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        stat_clr_a = 1'b0;
    logic        stat_clr_b = 1'b0;
    logic [15:0] cnt_total_a, cnt_cmp_a;
    logic [1:0]  cnt_total_b, cnt_cmp_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    rec_t qa[$];
    rec_t qb[$];
    rec_t cap_a, cap_b;

    eb1_ifu_compress_enc_if ifa ();
    eb1_ifu_compress_enc_if ifb ();

    eb1_ifu_compress_enc #(.ENABLE(1'b1), .CNT_W(16)) u_dut_a (
        .clk       (clk),
        .rst_l     (rst_l),
        .bus       (ifa),
        .stat_clr  (stat_clr_a),
        .cnt_total (cnt_total_a),
        .cnt_cmp   (cnt_cmp_a)
    );

    eb1_ifu_compress_enc #(.ENABLE(1'b0), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst_l     (rst_l),
        .bus       (ifb),
        .stat_clr  (stat_clr_b),
        .cnt_total (cnt_total_b),
        .cnt_cmp   (cnt_cmp_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every parcel that will be handed over at the next rising edge
    always @(negedge clk) begin
        if (rst_l && ifa.out_valid && ifa.out_ready) begin
            cap_a.parcel = ifa.out_parcel;
            cap_a.last   = ifa.out_last;
            cap_a.cmp    = ifa.out_compressed;
            cap_a.cyc    = cyc;
            qa.push_back(cap_a);
        end
        if (rst_l && ifb.out_valid && ifb.out_ready) begin
            cap_b.parcel = ifb.out_parcel;
            cap_b.last   = ifb.out_last;
            cap_b.cmp    = ifb.out_compressed;
            cap_b.cyc    = cyc;
            qb.push_back(cap_b);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? ifa.in_ready : ifb.in_ready;
    endfunction

    // Present one instruction and hold it until accepted (bounded)
    task automatic send(input int which, input logic [31:0] instr);
        int n = 0;
        if (which == 0) begin
            ifa.in_valid = 1'b1;
            ifa.in_instr = instr;
        end else begin
            ifb.in_valid = 1'b1;
            ifb.in_instr = instr;
        end
        @(negedge clk);
        while (!rdy(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(which)) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout dut=%0d: in_ready got 0 expected 1", which);
        end
        @(posedge clk);
        #1;
        if (which == 0) ifa.in_valid = 1'b0;
        else            ifb.in_valid = 1'b0;
    endtask

    // Take the next captured parcel (bounded wait)
    task automatic pop(input int which, output rec_t r);
        int n = 0;
        r.parcel = 16'h0;
        r.last   = 1'b0;
        r.cmp    = 1'b0;
        r.cyc    = -1;
        while (((which == 0) ? qa.size() : qb.size()) == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (((which == 0) ? qa.size() : qb.size()) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_timeout dut=%0d: got no parcel expected one", which);
        end else if (which == 0) begin
            r = qa.pop_front();
        end else begin
            r = qb.pop_front();
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[17];
    rec_t r;
    rec_t bb[4];

    initial begin
        vecs[0]  = '{0, 32'h0000_0013, 1'b0, 16'h0001, 1'b1, 16'h0000};
        vecs[1]  = '{0, 32'h0010_0073, 1'b0, 16'h9002, 1'b1, 16'h0000};
        vecs[2]  = '{0, 32'hFE00_8093, 1'b0, 16'h1081, 1'b1, 16'h0000};
        vecs[3]  = '{0, 32'h0200_8093, 1'b1, 16'h8093, 1'b0, 16'h0200};
        vecs[4]  = '{0, 32'h4094_0433, 1'b0, 16'h8C05, 1'b1, 16'h0000};
        vecs[5]  = '{0, 32'h0020_80B3, 1'b0, 16'h908A, 1'b1, 16'h0000};
        vecs[6]  = '{0, 32'h0002_80E7, 1'b0, 16'h9282, 1'b1, 16'h0000};
        vecs[7]  = '{0, 32'h00A4_C4B3, 1'b0, 16'h8CA9, 1'b1, 16'h0000};
        vecs[8]  = '{0, 32'h0087_F7B3, 1'b0, 16'h8FE1, 1'b1, 16'h0000};
        vecs[9]  = '{0, 32'h0000_4515, 1'b0, 16'h4515, 1'b0, 16'h0000};
        vecs[10] = '{0, 32'h0002_8293, 1'b1, 16'h8293, 1'b0, 16'h0002};
        vecs[11] = '{0, 32'h0104_6433, 1'b1, 16'h6433, 1'b0, 16'h0104};
        vecs[12] = '{1, 32'h0010_8093, 1'b1, 16'h8093, 1'b0, 16'h0010};
        vecs[13] = '{1, 32'h0000_4515, 1'b0, 16'h4515, 1'b0, 16'h0000};
        vecs[14] = '{1, 32'h0000_0013, 1'b1, 16'h0013, 1'b0, 16'h0000};
        vecs[15] = '{1, 32'h0010_0073, 1'b1, 16'h0073, 1'b0, 16'h0010};
        vecs[16] = '{1, 32'h4094_0433, 1'b1, 16'h0433, 1'b0, 16'h4094};

        ifa.in_valid = 1'b0;
        ifa.in_instr = 32'h0;
        ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0;
        ifb.in_instr = 32'h0;
        ifb.out_ready = 1'b1;

        // Reset state
        #1 rst_l = 1'b0;
        #1;
        chk("rst_out_valid", {31'h0, ifa.out_valid}, 32'h0);
        chk("rst_out_parcel", {16'h0, ifa.out_parcel}, 32'h0);
        chk("rst_out_last", {31'h0, ifa.out_last}, 32'h0);
        chk("rst_out_cmp", {31'h0, ifa.out_compressed}, 32'h0);
        chk("rst_cnt_total_a", {16'h0, cnt_total_a}, 32'h0);
        chk("rst_cnt_cmp_a", {16'h0, cnt_cmp_a}, 32'h0);
        chk("rst_cnt_total_b", {30'h0, cnt_total_b}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        chk("rst_in_ready", {31'h0, ifa.in_ready}, 32'h1);

        // lui: two parcels, input stalled between them
        send(0, 32'h1234_52B7);
        chk("lui_in_ready_between", {31'h0, ifa.in_ready}, 32'h0);
        chk("lui_cnt_total", {16'h0, cnt_total_a}, 32'h1);
        chk("lui_cnt_cmp", {16'h0, cnt_cmp_a}, 32'h0);
        pop(0, r);
        chk("lui_p0", {16'h0, r.parcel}, 32'h52B7);
        chk("lui_p0_last", {31'h0, r.last}, 32'h0);
        pop(0, r);
        chk("lui_p1", {16'h0, r.parcel}, 32'h1234);
        chk("lui_p1_last", {31'h0, r.last}, 32'h1);

        // Clear statistics
        settle(1);
        stat_clr_a = 1'b1;
        settle(1);
        stat_clr_a = 1'b0;
        chk("clr_cnt_total", {16'h0, cnt_total_a}, 32'h0);

        // Back-to-back compressible: one parcel per cycle
        send(0, 32'h0010_8093);
        send(0, 32'h0050_0513);
        send(0, 32'h00B0_0533);
        send(0, 32'h0000_8067);
        chk("b2b_cnt_cmp", {16'h0, cnt_cmp_a}, 32'h4);
        chk("b2b_cnt_total", {16'h0, cnt_total_a}, 32'h4);
        for (int i = 0; i < 4; i++) pop(0, bb[i]);
        chk("b2b_p0", {16'h0, bb[0].parcel}, 32'h0085);
        chk("b2b_p1", {16'h0, bb[1].parcel}, 32'h4515);
        chk("b2b_p2", {16'h0, bb[2].parcel}, 32'h852E);
        chk("b2b_p3", {16'h0, bb[3].parcel}, 32'h8082);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_flags%0d", i), {30'h0, bb[i].last, bb[i].cmp}, 32'h3);
            if (i > 0) chk($sformatf("b2b_cyc%0d", i), bb[i].cyc, bb[0].cyc + i);
        end

        // Vector table
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].which, vecs[i].instr);
            pop(vecs[i].which, r);
            chk($sformatf("v%0d_p0", i), {16'h0, r.parcel}, {16'h0, vecs[i].p0});
            chk($sformatf("v%0d_last0", i), {31'h0, r.last}, {31'h0, ~vecs[i].two});
            chk($sformatf("v%0d_cmp0", i), {31'h0, r.cmp}, {31'h0, vecs[i].c0});
            if (vecs[i].two) begin
                pop(vecs[i].which, r);
                chk($sformatf("v%0d_p1", i), {16'h0, r.parcel}, {16'h0, vecs[i].p1});
                chk($sformatf("v%0d_last1", i), {31'h0, r.last}, 32'h1);
                chk($sformatf("v%0d_cmp1", i), {31'h0, r.cmp}, 32'h0);
            end
        end
        settle(3);
        chk("tbl_qa_empty", qa.size(), 0);
        chk("tbl_qb_empty", qb.size(), 0);

        // Saturation on B: five accepts into a 2-bit counter
        chk("sat_cnt_total_b", {30'h0, cnt_total_b}, 32'h3);
        chk("sat_cnt_cmp_b", {30'h0, cnt_cmp_b}, 32'h0);

        // Clear wins over a same-cycle increment
        stat_clr_b = 1'b1;
        send(1, 32'h0000_4515);
        stat_clr_b = 1'b0;
        chk("clr_wins_b", {30'h0, cnt_total_b}, 32'h0);
        pop(1, r);
        send(1, 32'h0000_4515);
        chk("after_clr_b", {30'h0, cnt_total_b}, 32'h1);
        pop(1, r);

        // Backpressure while the high half is pending
        settle(2);
        ifa.out_ready = 1'b0;
        send(0, 32'h1234_52B7);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), {31'h0, ifa.out_valid}, 32'h1);
            chk($sformatf("bp_parcel%0d", k), {16'h0, ifa.out_parcel}, 32'h52B7);
            chk($sformatf("bp_last%0d", k), {31'h0, ifa.out_last}, 32'h0);
            chk($sformatf("bp_in_ready%0d", k), {31'h0, ifa.in_ready}, 32'h0);
        end
        @(posedge clk);
        #1 ifa.out_ready = 1'b1;
        pop(0, r);
        chk("bp_rel_p0", {16'h0, r.parcel}, 32'h52B7);
        pop(0, r);
        chk("bp_rel_p1", {16'h0, r.parcel}, 32'h1234);
        chk("bp_rel_p1_last", {31'h0, r.last}, 32'h1);
        settle(3);
        chk("bp_no_dup", qa.size(), 0);

        // Reset while HIGH_PEND drops the pending half
        ifa.out_ready = 1'b0;
        send(0, 32'h1234_52B7);
        #2 rst_l = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'h0, ifa.out_valid}, 32'h0);
        chk("rstmid_hi_clear", {31'h0, ifa.in_ready}, 32'h1);
        @(posedge clk);
        #1 rst_l = 1'b1;
        ifa.out_ready = 1'b1;
        send(0, 32'h0010_8093);
        pop(0, r);
        chk("rstmid_first", {16'h0, r.parcel}, 32'h0085);
        chk("rstmid_flags", {30'h0, r.last, r.cmp}, 32'h3);
        settle(3);
        chk("rstmid_no_stale", qa.size(), 0);
        chk("rstmid_cnt_total", {16'h0, cnt_total_a}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eb1_ifu_compress_enc.md
Name: eb1_ifu_compress_enc

Overview:
Streaming RV32 instruction compressor, the inverse of the IFU decompressor. It accepts 32-bit instructions over valid/ready, re-encodes a fixed RVC subset into 16-bit form, and emits a 16-bit parcel stream over valid/ready. Uncompressible instructions are emitted as two parcels, low half first. It is used by the compression regression flow and the program-image packer, and saturating counters report the compression ratio.

Parameters:
ENABLE, 1, 1 = compress the subset; 0 = emit every 32-bit instruction uncompressed.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
in_valid  in  1  in_instr is valid
in_ready  out  1  block accepts in_instr this cycle
in_instr  in  32  instruction to encode
out_valid  out  1  out_parcel is valid
out_ready  in  1  downstream accepts the parcel
out_parcel  out  16  output halfword
out_last  out  1  final parcel of the current instruction
out_compressed  out  1  parcel is an RVC encoding produced by this block
stat_clr  in  1  synchronous clear of both counters
cnt_total  out  CNT_W  instructions accepted
cnt_cmp  out  CNT_W  instructions compressed

Behaviour:
- Reset values: out_valid=0, out_parcel=0, out_last=0, out_compressed=0, hi_valid=0, both counters 0. Reset mid-stream drops any pending high half.
- State: the output register, plus a high-half buffer (hi_valid, hi_half[15:0]). Two states: EMPTY (hi_valid=0) and HIGH_PEND (hi_valid=1).
- Advance: adv = ~out_valid | out_ready.
- in_ready = ~hi_valid & adv. The ready signal is combinational from out_ready and registered state only, never from in_valid.
- Accept (in_valid & in_ready), data appears on the output 1 cycle later:
  - Compressible (ENABLE=1, in the subset): out_parcel = RVC code, out_last=1, out_compressed=1.
  - in_instr[1:0] != 2'b11 (already 16-bit): out_parcel = in_instr[15:0], out_last=1, out_compressed=0.
  - Otherwise: out_parcel = in_instr[15:0], out_last=0, out_compressed=0; hi_half = in_instr[31:16], hi_valid=1 (go to HIGH_PEND).
- In HIGH_PEND with adv: out_parcel = hi_half, out_last=1, out_compressed=0; hi_valid=0.
- Neither source with adv: out_valid=0. With out_valid & ~out_ready, all output fields hold stable.
- Throughput: 1 instruction/cycle when compressed; 1 per 2 cycles when uncompressed.
- Compressible subset (ENABLE=1), first match wins; rd'/rs2' means x8..x15, encoded as reg-8:
  - addi x0,x0,0 -> C.NOP 0x0001.
  - ebreak 0x00100073 -> C.EBREAK 0x9002.
  - addi rd,rd,imm, rd!=0, imm!=0, -32<=imm<=31 -> C.ADDI {3'b000,imm[5],rd,imm[4:0],2'b01}.
  - addi rd,x0,imm, rd!=0, -32<=imm<=31 -> C.LI {3'b010,imm[5],rd,imm[4:0],2'b01}.
  - add rd,x0,rs2, rd!=0, rs2!=0 -> C.MV {4'b1000,rd,rs2,2'b10}.
  - add rd,rd,rs2, rd!=0, rs2!=0 -> C.ADD {4'b1001,rd,rs2,2'b10}.
  - jalr x0,0(rs1), rs1!=0 -> C.JR {4'b1000,rs1,5'b0,2'b10}.
  - jalr x1,0(rs1), rs1!=0 -> C.JALR {4'b1001,rs1,5'b0,2'b10}.
  - sub/xor/or/and rd',rd',rs2' -> {6'b100011,rd'[2:0],op,rs2'[2:0],2'b01}, with op 00/01/10/11 respectively.
- Immediate check: imm = in_instr[31:20] sign-extended; in range iff in_instr[31:25] is all 0s or all 1s.
- Counters update on accept: cnt_total +1; cnt_cmp +1 when compressed. Both saturate at all-ones. stat_clr wins over a same-cycle increment.

Test Plan:
- ENABLE=1, out_ready=1: 0x00108093, 0x00500513, 0x00b00533, 0x00008067 back to back -> parcels 0x0085, 0x4515, 0x852E, 0x8082 on consecutive cycles, each out_last=1 and out_compressed=1; cnt_cmp=4.
- 0x123452B7 (lui) -> 0x52B7 (last=0), then 0x1234 (last=1); in_ready=0 in the cycle between the two parcels; cnt_total=1, cnt_cmp=0.
- Backpressure: out_ready=0 for 5 cycles while an uncompressed instruction is pending -> parcel held stable, in_ready=0, no parcel lost or duplicated after release.
- Boundaries: addi x1,x1,32 (0x02008093) -> two parcels; addi x1,x1,-32 (0xFE008093) -> 0x1081; 0x00000013 -> 0x0001; 0x00100073 -> 0x9002; sub x8,x8,x9 (0x40940433) -> 0x8C05.
- ENABLE=0: 0x00108093 -> 0x8093 then 0x0010; an input with [1:0]=01, e.g. 0x00004515 -> single parcel 0x4515, out_compressed=0.
- rst_l asserted in HIGH_PEND -> out_valid=0 and hi_valid=0 immediately; after release the next instruction's first parcel is emitted with no stale half. Saturation: CNT_W=2, 5 accepts -> cnt_total=3.
